// File: rtl/rsa_two_power_mod_multistep.sv
// 2^P mod N by repeated modular doubling, STEP doublings chained per RUN cycle.
// One job in flight; the result is held in DONE until the consumer takes it.
module rsa_two_power_mod_multistep #(
  parameter int WIDTH     = 256,
  parameter int PWR_WIDTH = 32,
  parameter int STEP      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [PWR_WIDTH-1:0] i_power,
  input  logic [WIDTH-1:0]     i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic                 o_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     n_q, n_nxt, acc_q, acc_nxt, acc_step;
  logic [PWR_WIDTH-1:0] rem_q, rem_nxt, k;
  logic                 err_q, err_nxt;
  logic [WIDTH:0]       t;

  // Chain of up to STEP doublings; acc < N always, so one conditional subtract suffices.
  always_comb begin
    acc_step = acc_q;
    t        = '0;
    for (int i = 0; i < STEP; i++) begin
      if (rem_q > PWR_WIDTH'(i)) begin
        t = {acc_step, 1'b0};
        if (t >= {1'b0, n_q}) t = t - {1'b0, n_q};
        acc_step = t[WIDTH-1:0];
      end
    end
  end

  assign k = (rem_q > PWR_WIDTH'(STEP)) ? PWR_WIDTH'(STEP) : rem_q;

  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    rem_nxt   = rem_q;
    acc_nxt   = acc_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (i_valid) begin
          n_nxt   = i_modulus;
          rem_nxt = i_power;
          err_nxt = 1'b0;
          acc_nxt = (i_modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
          if (i_modulus == '0) begin
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            state_nxt = DONE;
          end else if (i_power == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        acc_nxt = acc_step;
        rem_nxt = rem_q - k;
        if (rem_q == k) state_nxt = DONE;
      end
      DONE: begin
        if (o_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n_q   <= '0;
      rem_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      n_q   <= n_nxt;
      rem_q <= rem_nxt;
      acc_q <= acc_nxt;
      err_q <= err_nxt;
    end
  end

  assign i_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_result = acc_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_rsa_two_power_mod_multistep.sv
// Bench: four 8-bit lanes (STEP 4,1,3,8) sharing stimulus, plus one 256-bit instance.
// Expected values come from a wide-shift-and-modulo reference and are queued per job.
module tb_rsa_two_power_mod_multistep;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_power = '0;
  logic [7:0] i_modulus = '0;
  logic       o_ready = 1'b0;
  logic [3:0] l_irdy, l_ovld, l_oerr;
  logic [7:0] l_res [4];

  logic         b_vld = 1'b0;
  logic [31:0]  b_pow = '0;
  logic [255:0] b_mod = '0;
  logic         b_ordy = 1'b0;
  logic         b_irdy, b_ovld, b_err;
  logic [255:0] b_res;

  int checks = 0;
  int failures = 0;
  int lat [4];

  typedef struct {
    logic [7:0] n;
    logic [7:0] p;
    logic [7:0] res;
    logic       err;
  } job_t;
  job_t sb [$];
  logic [255:0] wq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    rsa_two_power_mod_multistep #(
      .WIDTH(8), .PWR_WIDTH(8), .STEP(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 3 : 8)
    ) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(l_irdy[g]),
      .i_power(i_power), .i_modulus(i_modulus),
      .o_valid(l_ovld[g]), .o_ready(o_ready),
      .o_result(l_res[g]), .o_err(l_oerr[g])
    );
  end

  rsa_two_power_mod_multistep #(.WIDTH(256), .PWR_WIDTH(32), .STEP(2)) dut_wide (
    .clk(clk), .rst(rst),
    .i_valid(b_vld), .i_ready(b_irdy),
    .i_power(b_pow), .i_modulus(b_mod),
    .o_valid(b_ovld), .o_ready(b_ordy),
    .o_result(b_res), .o_err(b_err)
  );

  function automatic int lane_step(input int l);
    return (l == 0) ? 4 : (l == 1) ? 1 : (l == 2) ? 3 : 8;
  endfunction

  function automatic logic [7:0] ref_pow(input logic [7:0] n, input logic [7:0] p);
    logic [263:0] x;
    if (n == 8'd0) return 8'd0;
    x = 264'(1) << p;
    return 8'(x % 264'(n));
  endfunction

  function automatic int exp_lat(input logic [7:0] n, input logic [7:0] p, input int step);
    if (n == 8'd0 || p == 8'd0) return 1;
    return (int'(p) + step - 1) / step + 1;
  endfunction

  task automatic start_job(input logic [7:0] n, input logic [7:0] p);
    job_t j;
    int b;
    j.n = n; j.p = p; j.err = (n == 8'd0); j.res = ref_pow(n, p);
    sb.push_back(j);
    @(negedge clk);
    i_modulus = n; i_power = p; i_valid = 1'b1;
    b = 0;
    while (l_irdy != 4'hF && b < 50) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (l_irdy !== 4'hF) begin
      failures++;
      $display("FAIL accept_timeout i_ready=%b required=1111", l_irdy);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_power = 8'($urandom);
    i_modulus = 8'($urandom);
  endtask

  task automatic wait_done;
    for (int l = 0; l < 4; l++) lat[l] = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) if (l_ovld[l] && lat[l] == 0) lat[l] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
  endtask

  task automatic release_job;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (l_ovld !== 4'h0) begin failures++; $display("FAIL reset_o_valid got=%b want=0000", l_ovld); end
    checks++;
    if (l_oerr !== 4'h0) begin failures++; $display("FAIL reset_o_err got=%b want=0000", l_oerr); end
    checks++;
    if (l_res[0] !== 8'd0) begin failures++; $display("FAIL reset_o_result got=%0d want=0", l_res[0]); end
    checks++;
    if (l_irdy !== 4'hF) begin failures++; $display("FAIL reset_i_ready got=%b want=1111", l_irdy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Table of directed jobs issued back to back, covering exact-N reduction and corner moduli.
  task automatic test_directed;
    logic [7:0] dn [9];
    logic [7:0] dp [9];
    job_t j;
    dn = '{8'd13, 8'd16, 8'd255, 8'd13, 8'd1, 8'd0, 8'd255, 8'd13, 8'd2};
    dp = '{8'd10, 8'd4,  8'd8,   8'd0,  8'd5, 8'd7, 8'd255, 8'd1,  8'd255};
    for (int i = 0; i < 9; i++) begin
      start_job(dn[i], dp[i]);
      wait_done;
      j = sb.pop_front();
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (l_res[l] !== j.res) begin
          failures++;
          $display("FAIL directed_result lane=%0d N=%0d P=%0d got=%0d want=%0d", l, j.n, j.p, l_res[l], j.res);
        end
        checks++;
        if (l_oerr[l] !== j.err) begin
          failures++;
          $display("FAIL directed_err lane=%0d N=%0d P=%0d got=%b want=%b", l, j.n, j.p, l_oerr[l], j.err);
        end
        checks++;
        if (lat[l] != exp_lat(j.n, j.p, lane_step(l))) begin
          failures++;
          $display("FAIL directed_latency lane=%0d N=%0d P=%0d got=%0d want=%0d", l, j.n, j.p, lat[l], exp_lat(j.n, j.p, lane_step(l)));
        end
      end
      release_job;
    end
  endtask

  task automatic test_backpressure;
    job_t j;
    start_job(8'd13, 8'd10);
    wait_done;
    j = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (l_ovld[0] !== 1'b1 || l_res[0] !== j.res) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b result=%0d want valid=1 result=%0d", c, l_ovld[0], l_res[0], j.res);
      end
      checks++;
      if (l_irdy !== 4'h0) begin failures++; $display("FAIL bp_i_ready cycle=%0d got=%b want=0000", c, l_irdy); end
    end
    o_ready = 1'b1;
    #1;
    checks++;
    if (l_irdy !== 4'h0) begin failures++; $display("FAIL bp_same_cycle_i_ready got=%b want=0000", l_irdy); end
    @(negedge clk);
    o_ready = 1'b0;
    checks++;
    if (l_ovld !== 4'h0) begin failures++; $display("FAIL bp_release_o_valid got=%b want=0000", l_ovld); end
    checks++;
    if (l_irdy !== 4'hF) begin failures++; $display("FAIL bp_release_i_ready got=%b want=1111", l_irdy); end
  endtask

  task automatic test_reset_mid_run;
    job_t j;
    start_job(8'd13, 8'd200);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++;
    if (l_ovld !== 4'h0 || l_oerr !== 4'h0) begin
      failures++;
      $display("FAIL midrun_reset_flags valid=%b err=%b want 0000/0000", l_ovld, l_oerr);
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (l_res[l] !== 8'd0) begin failures++; $display("FAIL midrun_reset_result lane=%0d got=%0d want=0", l, l_res[l]); end
    end
    @(negedge clk);
    rst = 1'b1;
    start_job(8'd13, 8'd10);
    wait_done;
    j = sb.pop_front();
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (l_res[l] !== j.res || lat[l] != exp_lat(j.n, j.p, lane_step(l))) begin
        failures++;
        $display("FAIL after_reset_job lane=%0d result=%0d lat=%0d want result=%0d lat=%0d", l, l_res[l], lat[l], j.res, exp_lat(j.n, j.p, lane_step(l)));
      end
    end
    release_job;
  endtask

  task automatic test_random;
    job_t j;
    for (int i = 0; i < 40; i++) begin
      start_job(8'($urandom_range(2, 255)), 8'($urandom_range(0, 255)));
      wait_done;
      j = sb.pop_front();
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (l_res[l] !== j.res || l_oerr[l] !== 1'b0 || lat[l] != exp_lat(j.n, j.p, lane_step(l))) begin
          failures++;
          $display("FAIL random lane=%0d N=%0d P=%0d result=%0d err=%b lat=%0d want result=%0d err=0 lat=%0d",
                   l, j.n, j.p, l_res[l], l_oerr[l], lat[l], j.res, exp_lat(j.n, j.p, lane_step(l)));
        end
      end
      release_job;
    end
  endtask

  task automatic test_wide;
    logic [255:0] wn [3];
    int           wp [3];
    logic [519:0] x;
    logic [255:0] expv;
    int           b, c;
    wn[0] = '1;
    wn[1] = 256'd1 << 255;
    wn[2] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} | (256'd1 << 255);
    wp = '{300, 255, 511};
    for (int i = 0; i < 3; i++) begin
      x = 520'(1) << wp[i];
      wq.push_back(256'(x % {264'd0, wn[i]}));
      @(negedge clk);
      b_mod = wn[i]; b_pow = 32'(wp[i]); b_vld = 1'b1;
      b = 0;
      while (!b_irdy && b < 50) begin @(negedge clk); b++; end
      @(posedge clk);
      #1;
      b_vld = 1'b0;
      b_mod = '0;
      c = 0;
      for (int k = 1; k <= 600; k++) begin
        @(negedge clk);
        if (b_ovld) begin c = k; break; end
      end
      expv = wq.pop_front();
      checks++;
      if (b_res !== expv || b_err !== 1'b0) begin
        failures++;
        $display("FAIL wide_result case=%0d got=%h err=%b want=%h err=0", i, b_res, b_err, expv);
      end
      checks++;
      if (c != (wp[i] + 1) / 2 + 1) begin
        failures++;
        $display("FAIL wide_latency case=%0d got=%0d want=%0d", i, c, (wp[i] + 1) / 2 + 1);
      end
      b_ordy = 1'b1;
      @(posedge clk);
      #1;
      b_ordy = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    test_wide;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
